uart_debug_ctrl: RTL and testbench

- Debug controller between the UART and the MIPS core.
- Decodes single-byte commands from the UART receiver and gates the core clock enable (run, step, reset).
- After execution, streams a dump of the core's debug-visible words plus a 32-bit executed-cycle counter back through the UART transmitter.
- Sits in TOP between the UART instance (rx_data/rx_data_rdy in, w_data/write_enable out) and the core debug port.

---
 rtl/uart_debug_ctrl_if.sv | 28 ++
 rtl/uart_debug_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_debug_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_debug_ctrl_if.sv
// Bundle of the UART-side and core-debug-side signals of the debug controller.
// The master modport is the controller; the slave modport is the UART and
// core environment around it.
interface uart_debug_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic [7:0]        rx_data;
   logic              rx_data_rdy;
   logic              tx_done;
   logic [7:0]        w_data;
   logic              write_enable;
   logic              cpu_halt;
   logic              cpu_en;
   logic              cpu_rst;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       dbg_data;
   logic              busy;

   modport master (
      input  rx_data, rx_data_rdy, tx_done, cpu_halt, dbg_data,
      output w_data, write_enable, cpu_en, cpu_rst, dbg_addr, busy
   );

   modport slave (
      output rx_data, rx_data_rdy, tx_done, cpu_halt, dbg_data,
      input  w_data, write_enable, cpu_en, cpu_rst, dbg_addr, busy
   );
endinterface

// File: rtl/uart_debug_ctrl.sv
// UART debug controller: decodes single-byte commands, gates the core clock
// enable for run/step/reset, and streams the debug words plus the executed
// cycle counter back out through the UART transmitter, LSB first.
module uart_debug_ctrl #(
   parameter int NUM_WORDS  = 36,
   parameter int ADDR_W     = 6,
   parameter int RST_CYCLES = 4
) (
   input logic              clk,
   input logic              rst,
   uart_debug_ctrl_if.master bus
);
   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] RUN      = 4'd1;
   localparam logic [3:0] STEP     = 4'd2;
   localparam logic [3:0] CPU_RST  = 4'd3;
   localparam logic [3:0] RD_ADDR  = 4'd4;
   localparam logic [3:0] RD_WAIT  = 4'd5;
   localparam logic [3:0] RD_LATCH = 4'd6;
   localparam logic [3:0] SEND     = 4'd7;
   localparam logic [3:0] WAIT_TX  = 4'd8;

   localparam int IDX_W = $clog2(NUM_WORDS + 1);
   localparam int RST_W = $clog2(RST_CYCLES) + 1;

   logic [3:0]        state, state_next;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        byte_idx;
   logic [RST_W-1:0]  rst_cnt;
   logic              ack;
   logic [31:0]       shreg;
   logic [31:0]       word_sel;
   logic [31:0]       cycle_cnt;
   logic [7:0]        w_data_q;
   logic              write_enable_q;
   logic              cpu_rst_q;
   logic [ADDR_W-1:0] dbg_addr_q;
   logic              busy_q;
   logic              cpu_en_c;

   // A halted core never gets an enable, and reset kills the enable at once.
   assign cpu_en_c = ~rst & ~bus.cpu_halt & ((state == STEP) | (state == RUN));

   assign bus.cpu_en       = cpu_en_c;
   assign bus.w_data       = w_data_q;
   assign bus.write_enable = write_enable_q;
   assign bus.cpu_rst      = cpu_rst_q;
   assign bus.dbg_addr     = dbg_addr_q;
   assign bus.busy         = busy_q;

   // The word after the last debug word is the executed-cycle counter.
   assign word_sel = (idx == IDX_W'(NUM_WORDS)) ? cycle_cnt : bus.dbg_data;

   // Next-state decode; bytes arriving outside IDLE never reach the decoder.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.rx_data_rdy) begin
               case (bus.rx_data)
                  8'h63:   state_next = RUN;
                  8'h73:   state_next = STEP;
                  8'h64:   state_next = RD_ADDR;
                  8'h72:   state_next = CPU_RST;
                  default: state_next = IDLE;
               endcase
            end
         end
         RUN:      if (bus.cpu_halt) state_next = RD_ADDR;
         STEP:     state_next = RD_ADDR;
         CPU_RST:  if (rst_cnt == RST_W'(RST_CYCLES - 1)) state_next = SEND;
         RD_ADDR:  state_next = RD_WAIT;
         RD_WAIT:  state_next = RD_LATCH;
         RD_LATCH: state_next = SEND;
         SEND:     state_next = WAIT_TX;
         WAIT_TX: begin
            if (bus.tx_done) begin
               if (ack)                         state_next = IDLE;
               else if (byte_idx != 2'd3)       state_next = SEND;
               else if (idx == IDX_W'(NUM_WORDS)) state_next = IDLE;
               else                             state_next = RD_ADDR;
            end
         end
         default:  state_next = IDLE;
      endcase
   end

   // State, counters and registered outputs; each byte is loaded into w_data
   // on the transition into SEND so write_enable is high during SEND itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         byte_idx       <= '0;
         rst_cnt        <= '0;
         ack            <= 1'b0;
         shreg          <= '0;
         cycle_cnt      <= '0;
         w_data_q       <= 8'h00;
         write_enable_q <= 1'b0;
         cpu_rst_q      <= 1'b0;
         dbg_addr_q     <= '0;
         busy_q         <= 1'b0;
      end else begin
         state          <= state_next;
         busy_q         <= (state_next != IDLE);
         cpu_rst_q      <= (state_next == CPU_RST);
         write_enable_q <= 1'b0;
         if (cpu_en_c) cycle_cnt <= cycle_cnt + 32'd1;
         case (state)
            IDLE: begin
               idx     <= '0;
               rst_cnt <= '0;
               ack     <= 1'b0;
            end
            CPU_RST: begin
               rst_cnt   <= rst_cnt + 1'b1;
               cycle_cnt <= '0;
               if (state_next == SEND) begin
                  w_data_q       <= 8'h52;
                  write_enable_q <= 1'b1;
                  ack            <= 1'b1;
               end
            end
            RD_ADDR:  dbg_addr_q <= ADDR_W'(idx);
            RD_LATCH: begin
               shreg          <= {8'h00, word_sel[31:8]};
               w_data_q       <= word_sel[7:0];
               write_enable_q <= 1'b1;
               byte_idx       <= 2'd0;
            end
            WAIT_TX: begin
               if (state_next == SEND) begin
                  w_data_q       <= shreg[7:0];
                  shreg          <= {8'h00, shreg[31:8]};
                  write_enable_q <= 1'b1;
                  byte_idx       <= byte_idx + 2'd1;
               end
               if (state_next == RD_ADDR) idx <= idx + 1'b1;
               if (state_next == IDLE) dbg_addr_q <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Testbench for uart_debug_ctrl: a UART transmitter stand-in answers every
// byte with tx_done, and a high-level model predicts the dump contents.
module tb_uart_debug_ctrl;
   localparam int NUM_WORDS = 36;
   localparam int ADDR_W    = 6;
   localparam int DUMP_LEN  = 4 * (NUM_WORDS + 1);

   logic clk;
   logic rst;

   uart_debug_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   uart_debug_ctrl #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .RST_CYCLES(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [64];
   logic [31:0] model_cnt;
   logic [7:0]  tx_q  [$];
   logic [7:0]  exp_q [$];
   int wr_cnt, en_cycles, rst_cycles, overlap, countdown;

   assign bus.dbg_data = mem[bus.dbg_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter stand-in and activity monitor
   initial begin
      bus.tx_done = 1'b0;
      countdown   = 0;
      forever begin
         @(negedge clk);
         bus.tx_done = 1'b0;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) bus.tx_done = 1'b1;
         end
         if (bus.write_enable === 1'b1) begin
            if (countdown > 0) overlap++;
            tx_q.push_back(bus.w_data);
            wr_cnt++;
            countdown = 10;
         end
         if (bus.cpu_en === 1'b1) en_cycles++;
         if (bus.cpu_rst === 1'b1) rst_cycles++;
      end
   end

   task automatic clear_mon();
      tx_q.delete();
      wr_cnt = 0; en_cycles = 0; rst_cycles = 0; overlap = 0;
   endtask

   // Expected dump: every debug word then the cycle counter, LSB first
   function automatic void build_expected();
      logic [31:0] w;
      exp_q.delete();
      for (int i = 0; i <= NUM_WORDS; i++) begin
         w = (i < NUM_WORDS) ? mem[i] : model_cnt;
         for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
      end
   endfunction

   function automatic int first_diff();
      if (tx_q.size() != exp_q.size()) return -2;
      for (int i = 0; i < exp_q.size(); i++)
         if (tx_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] last_word();
      int n = tx_q.size();
      if (n < 4) return 32'hxxxxxxxx;
      return {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data     = b;
      bus.rx_data_rdy = 1'b1;
      @(negedge clk);
      bus.rx_data_rdy = 1'b0;
      bus.rx_data     = $urandom;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (15) @(negedge clk);
   endtask

   task automatic test_reset();
      int bad = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({bus.w_data, bus.write_enable, bus.cpu_rst, bus.dbg_addr, bus.busy, bus.cpu_en} !== '0)
            bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("[TB] FAIL reset_idle: %0d cycles with nonzero outputs, required 0", bad); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
      checks++;
      if (bus.dbg_addr !== '0) begin errors++; $display("[TB] FAIL reset_dbg_addr: got %h required 0", bus.dbg_addr); end
      model_cnt = 32'd0;
   endtask

   task automatic test_step();
      bit ok;
      int d;
      for (int i = 0; i < 64; i++) mem[i] = 32'hA0000000 + i;
      bus.cpu_halt = 1'b0;
      clear_mon();
      send_cmd(8'h73);
      wait_done(ok);
      model_cnt = model_cnt + 1;
      build_expected();
      d = first_diff();
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL step_timeout: busy never dropped"); end
      checks++;
      if (en_cycles !== 1) begin errors++; $display("[TB] FAIL step_en_cycles: got %0d required 1", en_cycles); end
      checks++;
      if (wr_cnt !== DUMP_LEN) begin errors++; $display("[TB] FAIL step_byte_count: got %0d required %0d", wr_cnt, DUMP_LEN); end
      checks++;
      if (d !== -1) begin errors++; $display("[TB] FAIL step_dump: first difference at %0d (-2 = size)", d); end
      checks++;
      if (tx_q.size() >= 8 && {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5], tx_q[6], tx_q[7]} !== 64'h000000A0_010000A0)
      begin errors++; $display("[TB] FAIL step_first_words: got %h %h %h %h %h %h %h %h required 00 00 00 A0 01 00 00 A0",
            tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5], tx_q[6], tx_q[7]); end
      checks++;
      if (last_word() !== 32'h00000001) begin errors++; $display("[TB] FAIL step_counter_word: got %h required 00000001", last_word()); end
      checks++;
      if (overlap !== 0) begin errors++; $display("[TB] FAIL step_outstanding: %0d bytes sent before tx_done, required 0", overlap); end
   endtask

   task automatic test_reset_cmd();
      bit ok;
      int d;
      clear_mon();
      send_cmd(8'h72);
      wait_done(ok);
      model_cnt = 32'd0;
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL rstcmd_timeout: busy never dropped"); end
      checks++;
      if (rst_cycles !== 4) begin errors++; $display("[TB] FAIL rstcmd_cpu_rst_cycles: got %0d required 4", rst_cycles); end
      checks++;
      if (wr_cnt !== 1 || tx_q.size() < 1 || tx_q[0] !== 8'h52)
      begin errors++; $display("[TB] FAIL rstcmd_ack: got %0d bytes first %h required 1 byte 52", wr_cnt, tx_q.size() ? tx_q[0] : 8'hxx); end
      fill_random();
      clear_mon();
      send_cmd(8'h64);
      wait_done(ok);
      build_expected();
      d = first_diff();
      checks++;
      if (!ok || d !== -1) begin errors++; $display("[TB] FAIL rstcmd_dump: ok=%0d first difference at %0d", ok, d); end
      checks++;
      if (last_word() !== 32'h00000000) begin errors++; $display("[TB] FAIL rstcmd_counter_word: got %h required 00000000", last_word()); end
   endtask

   task automatic test_run_halt();
      bit ok;
      bit hit = 1'b0;
      int d;
      fill_random();
      bus.cpu_halt = 1'b0;
      clear_mon();
      send_cmd(8'h63);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if (en_cycles >= 1000) begin hit = 1'b1; break; end
      end
      @(posedge clk);
      #1 bus.cpu_halt = 1'b1;
      wait_done(ok);
      model_cnt = model_cnt + 1000;
      build_expected();
      d = first_diff();
      checks++;
      if (!hit || !ok) begin errors++; $display("[TB] FAIL run_timeout: hit=%0d ok=%0d required 1 1", hit, ok); end
      checks++;
      if (en_cycles !== 1000) begin errors++; $display("[TB] FAIL run_en_cycles: got %0d required 1000", en_cycles); end
      checks++;
      if (d !== -1) begin errors++; $display("[TB] FAIL run_dump: first difference at %0d", d); end
      checks++;
      if (last_word() !== 32'h000003E8) begin errors++; $display("[TB] FAIL run_counter_word: got %h required 000003E8", last_word()); end
      clear_mon();
      send_cmd(8'h63);
      wait_done(ok);
      checks++;
      if (!ok || en_cycles !== 0) begin errors++; $display("[TB] FAIL run_halted_en: ok=%0d en_cycles=%0d required 0", ok, en_cycles); end
      checks++;
      if (last_word() !== 32'h000003E8 || wr_cnt !== DUMP_LEN)
      begin errors++; $display("[TB] FAIL run_halted_dump: word %h bytes %0d required 000003E8 %0d", last_word(), wr_cnt, DUMP_LEN); end
      bus.cpu_halt = 1'b0;
   endtask

   task automatic test_dropped();
      bit ok;
      int d;
      fill_random();
      clear_mon();
      send_cmd(8'h41);
      repeat (20) @(negedge clk);
      checks++;
      if (wr_cnt !== 0 || en_cycles !== 0 || bus.busy !== 1'b0)
      begin errors++; $display("[TB] FAIL unknown_byte: bytes=%0d en=%0d busy=%b required 0 0 0", wr_cnt, en_cycles, bus.busy); end
      send_cmd(8'h64);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (wr_cnt >= 3) break;
      end
      send_cmd(8'h73);
      wait_done(ok);
      build_expected();
      d = first_diff();
      checks++;
      if (!ok || wr_cnt !== DUMP_LEN) begin errors++; $display("[TB] FAIL dropped_byte_count: got %0d required %0d", wr_cnt, DUMP_LEN); end
      checks++;
      if (en_cycles !== 0) begin errors++; $display("[TB] FAIL dropped_no_step: en_cycles %0d required 0", en_cycles); end
      checks++;
      if (d !== -1) begin errors++; $display("[TB] FAIL dropped_dump: first difference at %0d", d); end
   endtask

   task automatic test_random_run();
      bit ok;
      bit hit;
      int d;
      int n;
      for (int r = 0; r < 2; r++) begin
         n = $urandom_range(1, 300);
         hit = 1'b0;
         fill_random();
         clear_mon();
         send_cmd(8'h63);
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (en_cycles >= n) begin hit = 1'b1; break; end
         end
         @(posedge clk);
         #1 bus.cpu_halt = 1'b1;
         wait_done(ok);
         bus.cpu_halt = 1'b0;
         model_cnt = model_cnt + n;
         build_expected();
         d = first_diff();
         checks++;
         if (!hit || !ok || d !== -1)
         begin errors++; $display("[TB] FAIL random_run_%0d: n=%0d en=%0d first difference %0d", r, n, en_cycles, d); end
      end
   endtask

   task automatic test_reset_mid_dump();
      bit ok;
      int d;
      int held;
      fill_random();
      clear_mon();
      send_cmd(8'h64);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (wr_cnt >= 10) break;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_addr !== '0 || bus.cpu_en !== 1'b0)
      begin errors++; $display("[TB] FAIL midreset_outputs: we=%b busy=%b addr=%h en=%b required 0", bus.write_enable, bus.busy, bus.dbg_addr, bus.cpu_en); end
      rst = 1'b0;
      held = wr_cnt;
      repeat (30) @(negedge clk);
      checks++;
      if (wr_cnt !== held || held !== 10) begin errors++; $display("[TB] FAIL midreset_stopped: bytes %0d required 10", wr_cnt); end
      model_cnt = 32'd0;
      clear_mon();
      send_cmd(8'h64);
      wait_done(ok);
      build_expected();
      d = first_diff();
      checks++;
      if (!ok || d !== -1 || last_word() !== 32'h0)
      begin errors++; $display("[TB] FAIL midreset_counter: word %h first difference %0d required 00000000", last_word(), d); end
   endtask

   initial begin
      rst             = 1'b1;
      bus.rx_data     = 8'h00;
      bus.rx_data_rdy = 1'b0;
      bus.cpu_halt    = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      clear_mon();
      test_reset();
      test_step();
      test_reset_cmd();
      test_run_halt();
      test_dropped();
      test_random_run();
      test_reset_mid_dump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
